// File: rtl/wb_result_stage_if.sv
// Bundle between the writeback result stage and its neighbours: upstream issue,
// data-memory read response, and the register-file write port.
interface wb_result_stage_if #(
    parameter int NSRC = 4
);
    localparam int SW = $clog2(NSRC);

    // Upstream handshake: an instruction transfers on a rising edge where
    // valid_i && ready_o; while ready_o is low upstream holds valid_i and its fields.
    logic               valid_i;
    logic               ready_o;
    logic [NSRC*32-1:0] src_i;
    logic [SW-1:0]      ResultSrc_i;
    logic               RegWrite_i;
    logic [4:0]         Rd_i;
    logic [2:0]         Funct3_i;
    logic [1:0]         AddrLsb_i;
    logic               MemRvalid_i;
    logic [31:0]        MemRdata_i;
    logic               Valid_o;
    logic [31:0]        Result_o;
    logic [4:0]         Rd_o;
    logic               RegWrite_o;
    logic               MemTimeout_o;
    logic               dbg_state;

    modport slave (
        input  valid_i, src_i, ResultSrc_i, RegWrite_i, Rd_i, Funct3_i, AddrLsb_i,
        input  MemRvalid_i, MemRdata_i,
        output ready_o, Valid_o, Result_o, Rd_o, RegWrite_o, MemTimeout_o, dbg_state
    );

    modport master (
        output valid_i, src_i, ResultSrc_i, RegWrite_i, Rd_i, Funct3_i, AddrLsb_i,
        output MemRvalid_i, MemRdata_i,
        input  ready_o, Valid_o, Result_o, Rd_o, RegWrite_o, MemTimeout_o, dbg_state
    );
endinterface

// File: rtl/wb_result_stage.sv
// Writeback result selector: picks one of NSRC sources or an aligned load word,
// waits (bounded) for late memory responses and registers the regfile write.
module wb_result_stage #(
    parameter int NSRC     = 4,
    parameter int MEM_SRC  = 1,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    wb_result_stage_if.slave bus
);
    localparam int SW = $clog2(NSRC);

    typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [4:0]       cap_rd, cap_rd_d;
    logic [2:0]       cap_f3, cap_f3_d;
    logic [1:0]       cap_lsb, cap_lsb_d;
    logic             cap_we, cap_we_d;
    logic             valid_q, valid_d;
    logic [31:0]      result_q, result_d;
    logic [4:0]       rd_q, rd_d;
    logic             we_q, we_d;
    logic             tmo_q, tmo_d;
    logic [31:0]      src_word;
    logic             is_load;

    function automatic logic [31:0] align_load(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] lsb);
        logic [31:0] b;
        logic [15:0] h;
        b = w >> {lsb, 3'b000};
        h = lsb[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  align_load = {{24{b[7]}}, b[7:0]};
            3'b001:  align_load = {{16{h[15]}}, h};
            3'b100:  align_load = {24'h0, b[7:0]};
            3'b101:  align_load = {16'h0, h};
            default: align_load = w;
        endcase
    endfunction

    // Out-of-range selects fall back to source 0.
    always_comb begin
        src_word = bus.src_i[31:0];
        for (int k = 1; k < NSRC; k++) begin
            if (bus.ResultSrc_i == SW'(k)) src_word = bus.src_i[32*k +: 32];
        end
    end

    assign is_load = (int'(bus.ResultSrc_i) == MEM_SRC);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        cap_rd_d  = cap_rd;
        cap_f3_d  = cap_f3;
        cap_lsb_d = cap_lsb;
        cap_we_d  = cap_we;
        valid_d   = 1'b0;
        we_d      = 1'b0;
        result_d  = result_q;
        rd_d      = rd_q;
        tmo_d     = tmo_q;
        case (state)
            IDLE: begin
                if (bus.valid_i) begin
                    if (!is_load || bus.MemRvalid_i) begin
                        valid_d  = 1'b1;
                        rd_d     = bus.Rd_i;
                        we_d     = bus.RegWrite_i && (bus.Rd_i != 5'd0);
                        result_d = is_load ? align_load(bus.MemRdata_i, bus.Funct3_i, bus.AddrLsb_i)
                                           : src_word;
                    end else begin
                        state_d   = WAIT_MEM;
                        cnt_d     = '0;
                        cap_rd_d  = bus.Rd_i;
                        cap_f3_d  = bus.Funct3_i;
                        cap_lsb_d = bus.AddrLsb_i;
                        cap_we_d  = bus.RegWrite_i;
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.MemRvalid_i) begin
                    state_d  = IDLE;
                    valid_d  = 1'b1;
                    rd_d     = cap_rd;
                    we_d     = cap_we && (cap_rd != 5'd0);
                    result_d = align_load(bus.MemRdata_i, cap_f3, cap_lsb);
                end else if (cnt == CNT_W'(MAX_WAIT)) begin
                    // Retire as a non-writing bubble so the pipeline keeps moving.
                    state_d  = IDLE;
                    valid_d  = 1'b1;
                    rd_d     = cap_rd;
                    result_d = 32'h0;
                    tmo_d    = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_rd   <= '0;
            cap_f3   <= '0;
            cap_lsb  <= '0;
            cap_we   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
            we_q     <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            cap_rd   <= cap_rd_d;
            cap_f3   <= cap_f3_d;
            cap_lsb  <= cap_lsb_d;
            cap_we   <= cap_we_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.ready_o      = (state == IDLE);
    assign bus.Valid_o      = valid_q;
    assign bus.Result_o     = result_q;
    assign bus.Rd_o         = rd_q;
    assign bus.RegWrite_o   = we_q;
    assign bus.MemTimeout_o = tmo_q;
    assign bus.dbg_state    = state;
endmodule

// File: tb/tb_wb_result_stage.sv
// Randomized bench for wb_result_stage: a transaction-level model predicts each
// retirement (value and cycle) into an expected queue checked by a monitor.
module tb_wb_result_stage;
    localparam int NSRC     = 4;
    localparam int MEM_SRC  = 1;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;
    localparam int SW       = $clog2(NSRC);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_result_stage_if #(.NSRC(NSRC)) bus();

    wb_result_stage #(.NSRC(NSRC), .MEM_SRC(MEM_SRC), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    bit          model_tmo = 1'b0;
    logic [31:0] srcs [NSRC];
    // {result[31:0], rd[4:0], check_rd, regwrite, timeout}
    logic [39:0] exp_q[$];
    int          exp_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference load alignment using plain integer arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lsb);
        int unsigned byte_v, half_v;
        byte_v = (w >> (8 * int'(lsb))) & 32'hFF;
        half_v = (w >> (16 * (int'(lsb) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (byte_v < 128) ? byte_v : (byte_v | 32'hFFFF_FF00);
            3'd1:    return (half_v < 32768) ? half_v : (half_v | 32'hFFFF_0000);
            3'd4:    return byte_v;
            3'd5:    return half_v;
            default: return w;
        endcase
    endfunction

    task automatic push_exp(input logic [31:0] r, input logic [4:0] rd, input bit chk_rd, input bit we);
        exp_q.push_back({r, rd, chk_rd, we, model_tmo});
        exp_cyc_q.push_back(cyc + 1);
    endtask

    task automatic drive_srcs();
        for (int k = 0; k < NSRC; k++) bus.src_i[32*k +: 32] = srcs[k];
    endtask

    task automatic scramble();
        bus.Rd_i        = 5'($urandom);
        bus.Funct3_i    = 3'($urandom);
        bus.AddrLsb_i   = 2'($urandom);
        bus.RegWrite_i  = 1'($urandom);
        bus.ResultSrc_i = SW'($urandom);
        bus.MemRdata_i  = $urandom;
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    // delay 0: response with the request; delay k: response in the k-th stalled cycle.
    task automatic do_instr(input int sel, input logic [4:0] rd, input bit we, input logic [2:0] f3,
                            input logic [1:0] lsb, input logic [31:0] mdata, input int delay);
        bit is_load;
        bit done;
        is_load = (sel == MEM_SRC);
        drive_srcs();
        bus.valid_i     = 1'b1;
        bus.ResultSrc_i = SW'(sel);
        bus.Rd_i        = rd;
        bus.RegWrite_i  = we;
        bus.Funct3_i    = f3;
        bus.AddrLsb_i   = lsb;
        check("ready_idle", bus.ready_o, 1'b1);
        if (!is_load) begin
            bus.MemRvalid_i = 1'($urandom);
            bus.MemRdata_i  = $urandom;
            push_exp(srcs[sel], rd, 1'b1, we && (rd != 0));
            @(negedge clk);
        end else if (delay == 0) begin
            bus.MemRvalid_i = 1'b1;
            bus.MemRdata_i  = mdata;
            push_exp(ref_load(mdata, f3, lsb), rd, 1'b1, we && (rd != 0));
            @(negedge clk);
        end else begin
            bus.MemRvalid_i = 1'b0;
            @(negedge clk);
            for (int k = 1; k <= MAX_WAIT + 1; k++) begin
                check("ready_stall", bus.ready_o, 1'b0);
                scramble();
                bus.MemRvalid_i = (k == delay);
                if (k == delay) begin
                    bus.MemRdata_i = mdata;
                    push_exp(ref_load(mdata, f3, lsb), rd, 1'b1, we && (rd != 0));
                end else if (k == MAX_WAIT + 1) begin
                    model_tmo = 1'b1;
                    push_exp(32'h0, rd, 1'b0, 1'b0);
                end
                done = (k == delay) || (k == MAX_WAIT + 1);
                @(negedge clk);
                if (done) break;
            end
        end
        bus.valid_i = 1'b0;
        bus.MemRvalid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        bus.valid_i = 1'b0;
        repeat (n) begin
            scramble();
            bus.MemRvalid_i = 1'($urandom);
            @(negedge clk);
        end
        bus.MemRvalid_i = 1'b0;
    endtask

    task automatic rand_srcs();
        for (int k = 0; k < NSRC; k++) srcs[k] = $urandom;
    endtask

    // Scoreboard: every retirement must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.Valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", bus.Valid_o, 1'b0);
                end else begin
                    logic [39:0] e;
                    int          c;
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("ret_cycle", cyc, c);
                    check("ret_result", bus.Result_o, e[39:8]);
                    if (e[2]) check("ret_rd", bus.Rd_o, e[7:3]);
                    check("ret_regwrite", bus.RegWrite_o, e[1]);
                    check("ret_timeout", bus.MemTimeout_o, e[0]);
                end
            end else if (bus.RegWrite_o !== 1'b0) begin
                check("regwrite_without_valid", bus.RegWrite_o, 1'b0);
            end
        end
    end

    initial begin
        bus.valid_i = 1'b0;
        bus.MemRvalid_i = 1'b0;
        bus.src_i = '0;
        scramble();
        for (int k = 0; k < NSRC; k++) srcs[k] = '0;

        repeat (3) @(negedge clk);
        check("rst_valid", bus.Valid_o, 1'b0);
        check("rst_result", bus.Result_o, 32'h0);
        check("rst_rd", bus.Rd_o, 5'd0);
        check("rst_regwrite", bus.RegWrite_o, 1'b0);
        check("rst_timeout", bus.MemTimeout_o, 1'b0);
        check("rst_ready", bus.ready_o, 1'b1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Back-to-back ALU results
        rand_srcs();
        for (int i = 1; i <= 3; i++) begin
            srcs[0] = 32'(i);
            do_instr(0, 5'd5, 1'b1, 3'b010, 2'd0, 32'h0, 0);
        end
        check("t1_last_result", bus.Result_o, 32'h3);
        idle_cycles(2);

        // x0 destination never writes
        srcs[2] = 32'h100;
        do_instr(2, 5'd0, 1'b1, 3'b000, 2'd0, 32'h0, 0);
        check("t2_result", bus.Result_o, 32'h100);
        check("t2_regwrite", bus.RegWrite_o, 1'b0);
        idle_cycles(1);

        // Load alignment with same-cycle response
        do_instr(MEM_SRC, 5'd7, 1'b1, 3'b000, 2'd3, 32'h80FF_0000, 0);
        check("t3_lb", bus.Result_o, 32'hFFFF_FF80);
        do_instr(MEM_SRC, 5'd8, 1'b1, 3'b101, 2'd2, 32'h80FF_0000, 0);
        check("t3_lhu", bus.Result_o, 32'h0000_80FF);

        // Late LW, then the held instruction retires right after
        rand_srcs();
        do_instr(MEM_SRC, 5'd9, 1'b1, 3'b010, 2'd0, 32'hDEAD_BEEF, 3);
        check("t4_lw", bus.Result_o, 32'hDEAD_BEEF);
        do_instr(3, 5'd10, 1'b1, 3'b000, 2'd0, 32'h0, 0);
        // Response in the last cycle before timeout still delivers data
        do_instr(MEM_SRC, 5'd11, 1'b1, 3'b001, 2'd2, 32'h8001_1234, MAX_WAIT + 1);
        check("edge_lh", bus.Result_o, 32'hFFFF_8001);
        check("edge_no_timeout", bus.MemTimeout_o, 1'b0);

        // No response: timeout bubble, sticky flag
        do_instr(MEM_SRC, 5'd12, 1'b1, 3'b010, 2'd0, 32'h0, 1000);
        check("t5_valid", bus.Valid_o, 1'b1);
        check("t5_regwrite", bus.RegWrite_o, 1'b0);
        check("t5_timeout", bus.MemTimeout_o, 1'b1);
        idle_cycles(4);
        do_instr(0, 5'd1, 1'b1, 3'b000, 2'd0, 32'h0, 0);
        check("t5_sticky", bus.MemTimeout_o, 1'b1);
        idle_cycles(1);

        // Randomized mix
        for (int i = 0; i < 80; i++) begin
            int sel, dly, r;
            rand_srcs();
            sel = $urandom_range(0, NSRC - 1);
            r   = $urandom_range(0, 99);
            dly = (r < 50) ? 0 : (r < 95) ? $urandom_range(1, 6) : $urandom_range(MAX_WAIT, MAX_WAIT + 3);
            do_instr(sel, 5'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), $urandom, dly);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);
        check("queue_drained", exp_q.size(), 0);

        // Reset while a load is pending drops it
        drive_srcs();
        bus.valid_i = 1'b1;
        bus.ResultSrc_i = SW'(MEM_SRC);
        bus.Rd_i = 5'd13;
        bus.RegWrite_i = 1'b1;
        bus.Funct3_i = 3'b010;
        bus.MemRvalid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_stalled", bus.ready_o, 1'b0);
        rst_n = 1'b0;
        bus.valid_i = 1'b0;
        @(negedge clk);
        check("t6_valid", bus.Valid_o, 1'b0);
        check("t6_result", bus.Result_o, 32'h0);
        check("t6_rd", bus.Rd_o, 5'd0);
        check("t6_timeout", bus.MemTimeout_o, 1'b0);
        check("t6_ready", bus.ready_o, 1'b1);
        model_tmo = 1'b0;
        rst_n = 1'b1;
        bus.MemRvalid_i = 1'b1;
        bus.MemRdata_i = 32'h1234_5678;
        @(negedge clk);
        check("t6_no_retire", bus.Valid_o, 1'b0);
        check("t6_ready_after", bus.ready_o, 1'b1);
        bus.MemRvalid_i = 1'b0;
        idle_cycles(2);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
